dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (dm).
- Sits between the processor top (master 0) and a debug/loader port (master 1) on one side, and the dm instance on the other.
- Serialises accesses with at most one transaction in flight.
- Drives the dm control strobes, and returns read data with a valid pulse to the winning master.

Parameters:
- ADDR_W, 12, dm word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, dm read latency in cycles from the enable+read edge to DM_out valid; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 request; held until m0_gnt.
- m0_we  input  1  master 0: 1 = write, 0 = read.
- m0_addr  input  ADDR_W  master 0 address.
- m0_wdata  input  DATA_W  master 0 write data.
- m0_gnt  output  1  one-cycle pulse; request accepted.
- m0_rvalid  output  1  one-cycle pulse; m0_rdata valid.
- m0_rdata  output  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- DM_enable  output  1  dm enable.
- DM_read  output  1  dm read strobe.
- DM_write  output  1  dm write strobe.
- DM_address  output  ADDR_W  dm address.
- DM_in  output  DATA_W  dm write data.
- DM_out  input  DATA_W  dm read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last-winner pointer=1 (so master 0 wins the first tie).
  - All gnt, rvalid and DM_* strobes are 0; DM_address, DM_in and rdata are 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Sample m0_req and m1_req at the clock edge.
  - One requester: it wins.
  - Both requesting: round-robin; the master that is not the last winner wins.
  - Winner found: latch its we/addr/wdata, update the pointer, go to ISSUE.
  - No requester: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - DM_enable=1.
  - DM_write=we and DM_read=~we.
  - DM_address and DM_in carry the latched values.
  - The winner's gnt=1.
  - Write: go to IDLE next.
  - Read: go to WAIT with latency counter = MEM_LAT.
- WAIT:
  - All strobes are 0; the counter decrements each cycle.
  - When the counter reaches 1: capture DM_out into the winner's rdata, pulse its rvalid for 1 cycle, go to IDLE.
- Latency:
  - Request seen at edge N → gnt high during cycle N+1.
  - Read: rvalid high during cycle N+1+MEM_LAT.
  - Idle-to-idle cost: write = 2 cycles; read = 2+MEM_LAT cycles.
- The non-winning master keeps its req asserted and is evaluated again on the next return to IDLE.
- A master may lower req, or present a new request, the cycle after gnt.
- Master requirement: once granted a read, a master must not reissue before its rvalid.
- rdata holds its last value until that master's next read completes.
- Requester changing addr/we/wdata while waiting for grant: no effect on any transaction already latched.
- req deasserted before grant: the request is withdrawn with no side effect.
- Back-to-back with both masters requesting continuously: strict alternation 0,1,0,1.
- Reset asserted during ISSUE or WAIT: the transaction is aborted and no rvalid is produced. A dm write whose ISSUE edge already occurred is not undone.
- Only one of DM_read/DM_write is ever high; both are high only together with DM_enable.

Optional Feature:
- Macro: DM_ARB_FIXED_PRI_EN.
- Defined: strict priority; master 0 always wins a tie and the last-winner pointer is unused.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
1. Reset release, master 0 writes 32'hDEADBEEF to addr 12'h010, MEM_LAT=1:
   - m0_gnt pulses one cycle after req.
   - DM_write=1, DM_address=12'h010, DM_in=32'hDEADBEEF in that same cycle.
   - dm word 16 = 32'hDEADBEEF.
2. Master 1 reads addr 12'h010 after scenario 1, MEM_LAT=1 → m1_gnt, then 1 cycle later m1_rvalid=1 with m1_rdata=32'hDEADBEEF; m0_rvalid stays 0.
3. Both masters request reads every cycle for 8 transactions:
   - Grants alternate 0,1,0,1,… starting with 0.
   - With DM_ARB_FIXED_PRI_EN defined, all 8 grants go to master 0.
4. MEM_LAT=3, master 0 reads → gnt at cycle N+1, rvalid at cycle N+4; DM_enable high only in the gnt cycle.
5. rst driven low during WAIT of a master 1 read → all outputs 0 immediately (asynchronously, before the next edge); no m1_rvalid after release; the next request grants master 0 first on a tie.
6. m1_req raised then dropped while master 0's transaction is in progress → master 1 is never granted, and no extra DM_enable pulse occurs.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master arbiter/sequencer in front of the single-port data memory.
//   Master 0 is the processor top, master 1 the debug/loader port.
//   At most one transaction is in flight: IDLE picks a winner, ISSUE drives the
//   dm strobes for one cycle, and WAIT (reads only) counts MEM_LAT cycles before
//   returning the read data with a one-cycle rvalid pulse.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   mN_req/we/addr/wdata       master N request, held until mN_gnt
//   mN_gnt                     one-cycle accept pulse (the ISSUE cycle)
//   mN_rvalid/mN_rdata         read return; rdata holds until N's next read
//   DM_enable/read/write       dm strobes, high only in the ISSUE cycle
//   DM_address/DM_in           dm address and write data (0 outside ISSUE)
//   DM_out                     dm read data, sampled MEM_LAT edges after the
//                              edge that raises enable+read (MEM_LAT=1 means a
//                              dm whose read data is valid in the strobe cycle)
//
// Build option: define DM_ARB_FIXED_PRI_EN for strict priority (master 0 wins
// every tie); otherwise ties are resolved round-robin on the last winner.
// All outputs are registered.
module dm_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              DM_enable,
    output logic              DM_read,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic              ptr, ptr_n;       // last winner
    logic              win, win_n;       // master owning the transaction in flight
    logic              pick;             // arbitration result: 1 = master 1
    logic              cap;              // load rdata/rvalid at this edge
    logic              m0_gnt_n, m1_gnt_n, m0_rvalid_n, m1_rvalid_n;
    logic [DATA_W-1:0] m0_rdata_n, m1_rdata_n;
    logic              en_n, rd_n, wr_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n;

    always_comb begin
`ifdef DM_ARB_FIXED_PRI_EN
        pick = ~m0_req;
`else
        pick = (m0_req && m1_req) ? ~ptr : ~m0_req;
`endif
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ptr_n       = ptr;
        win_n       = win;
        cap         = 1'b0;
        m0_gnt_n    = 1'b0;
        m1_gnt_n    = 1'b0;
        m0_rvalid_n = 1'b0;
        m1_rvalid_n = 1'b0;
        m0_rdata_n  = m0_rdata;
        m1_rdata_n  = m1_rdata;
        en_n        = 1'b0;
        rd_n        = 1'b0;
        wr_n        = 1'b0;
        addr_n      = '0;
        din_n       = '0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // The DM_* output registers double as the latch for the
                    // winner's we/addr/wdata during ISSUE.
                    state_n  = ISSUE;
                    win_n    = pick;
                    ptr_n    = pick;
                    m0_gnt_n = ~pick;
                    m1_gnt_n = pick;
                    en_n     = 1'b1;
                    wr_n     = pick ? m1_we : m0_we;
                    rd_n     = ~wr_n;
                    addr_n   = pick ? m1_addr : m0_addr;
                    din_n    = pick ? m1_wdata : m0_wdata;
                end
            end
            ISSUE: begin
                if (DM_write) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                    cnt_n   = 3'(MEM_LAT);
                    // rvalid must be visible in the last WAIT cycle, so the
                    // capture happens on the edge that enters it.
                    cap     = (MEM_LAT == 1);
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 3'd1;
                    cap   = (cnt == 3'd2);
                end
            end
            default: state_n = IDLE;
        endcase
        if (cap) begin
            if (win) begin
                m1_rdata_n  = DM_out;
                m1_rvalid_n = 1'b1;
            end else begin
                m0_rdata_n  = DM_out;
                m0_rvalid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= 1'b1;
            win        <= 1'b0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            DM_enable  <= 1'b0;
            DM_read    <= 1'b0;
            DM_write   <= 1'b0;
            DM_address <= '0;
            DM_in      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            win        <= win_n;
            m0_gnt     <= m0_gnt_n;
            m1_gnt     <= m1_gnt_n;
            m0_rvalid  <= m0_rvalid_n;
            m1_rvalid  <= m1_rvalid_n;
            m0_rdata   <= m0_rdata_n;
            m1_rdata   <= m1_rdata_n;
            DM_enable  <= en_n;
            DM_read    <= rd_n;
            DM_write   <= wr_n;
            DM_address <= addr_n;
            DM_in      <= din_n;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: u_dut (MEM_LAT=1) against an array dm model, u_dut3
// (MEM_LAT=3) against a pipelined address-pattern dm model.
module tb_dm_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- DUT, MEM_LAT = 1 ----------------
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          dm_en, dm_rd, dm_wr;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_in, dm_out;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .DM_enable(dm_en), .DM_read(dm_rd), .DM_write(dm_wr),
        .DM_address(dm_addr), .DM_in(dm_in), .DM_out(dm_out)
    );

    // dm with read data valid in the strobe cycle
    logic [DW-1:0] mem1 [0:4095];
    always @(posedge clk) if (dm_en && dm_wr) mem1[dm_addr] <= dm_in;
    assign dm_out = (dm_en && dm_rd) ? mem1[dm_addr] : '0;

    // ---------------- DUT, MEM_LAT = 3 ----------------
    logic          d3_m0_req, d3_m0_we, d3_m1_req, d3_m1_we;
    logic [AW-1:0] d3_m0_addr, d3_m1_addr;
    logic [DW-1:0] d3_m0_wdata, d3_m1_wdata;
    logic          d3_m0_gnt, d3_m1_gnt, d3_m0_rvalid, d3_m1_rvalid;
    logic [DW-1:0] d3_m0_rdata, d3_m1_rdata;
    logic          d3_en, d3_rd, d3_wr;
    logic [AW-1:0] d3_addr;
    logic [DW-1:0] d3_in, d3_out;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata),
        .m0_gnt(d3_m0_gnt), .m0_rvalid(d3_m0_rvalid), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata),
        .m1_gnt(d3_m1_gnt), .m1_rvalid(d3_m1_rvalid), .m1_rdata(d3_m1_rdata),
        .DM_enable(d3_en), .DM_read(d3_rd), .DM_write(d3_wr),
        .DM_address(d3_addr), .DM_in(d3_in), .DM_out(d3_out)
    );

    // read-only dm returning a pattern of the address, 3 cycles from the strobe edge
    logic [DW-1:0] d3_rd0, d3_p1, d3_p2;
    assign d3_rd0 = (d3_en && d3_rd) ? {20'hC0DE0, d3_addr} : '0;
    always @(posedge clk) begin
        d3_p1 <= d3_rd0;
        d3_p2 <= d3_p1;
    end
    assign d3_out = d3_p2;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for u_dut ----------------
    logic        gnt_q[$];   // expected winner of each grant
    logic [32:0] rd_q[$];    // expected {master, rdata} of each read return
    int          en_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            logic        eg;
            logic [32:0] er;
            if (dm_en) en_cnt++;
            chk("strobe_excl", {62'd0, dm_rd & dm_wr, (dm_rd | dm_wr) & ~dm_en}, 64'd0);
            if (m0_gnt || m1_gnt) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", {62'd0, m1_gnt, m0_gnt}, 64'd0);
                end else begin
                    eg = gnt_q.pop_front();
                    chk("gnt_order", {62'd0, m1_gnt, m0_gnt}, eg ? 64'd2 : 64'd1);
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("rvalid_unexpected", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
                end else begin
                    er = rd_q.pop_front();
                    chk("rd_data", {30'd0, m1_rvalid, m0_rvalid, m1_rvalid ? m1_rdata : m0_rdata},
                        {30'd0, er[32], ~er[32], er[31:0]});
                end
            end
        end
    end

    // one table transaction on u_dut, returning to IDLE before exit
    task automatic do_txn(input logic m, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        int w;
        gnt_q.push_back(m);
        if (!we) rd_q.push_back({m, exp_rd});
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = wd;
        end
        w = 0;
        do begin
            tick();
            w++;
        end while (!(m ? m1_gnt : m0_gnt) && w < 20);
        chk("gnt_latency", 64'(w), 64'd1);
        chk("dm_strobes", {61'd0, dm_en, dm_wr, dm_rd}, {61'd0, 1'b1, we, ~we});
        chk("dm_address", 64'(dm_addr), 64'(a));
        if (we) chk("dm_in", 64'(dm_in), 64'(wd));
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        if (!we) begin
            chk("rvalid_latency", {62'd0, m1_rvalid, m0_rvalid}, m ? 64'd2 : 64'd1);
            tick();
        end
    endtask

    typedef struct {
        logic          m;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [DW-1:0] last_rd[2];
        logic          em;
        int            ng, cyc, last, e0;

        tbl[0] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 12'h000, 32'hA5A5A5A5, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 12'hFFF, 32'hFFFFFFFF, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 12'h000, 32'h0,        32'hA5A5A5A5};
        tbl[5] = '{1'b1, 1'b0, 12'hFFF, 32'h0,        32'hFFFFFFFF};
        tbl[6] = '{1'b1, 1'b1, 12'h010, 32'h12345678, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 12'h010, 32'h0,        32'h12345678};
        tbl[8] = '{1'b1, 1'b1, 12'h020, 32'h0F0F0F0F, 32'h0};
        tbl[9] = '{1'b0, 1'b0, 12'h020, 32'h0,        32'h0F0F0F0F};

        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        d3_m0_req = 0; d3_m0_we = 0; d3_m0_addr = '0; d3_m0_wdata = '0;
        d3_m1_req = 0; d3_m1_we = 0; d3_m1_addr = '0; d3_m1_wdata = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        // reset state
        #2;
        chk("reset_ctl", {58'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dm_en, dm_rd | dm_wr}, 64'd0);
        chk("reset_rdata", {m0_rdata, m1_rdata}, 64'd0);
        chk("reset_bus", {20'd0, dm_addr, dm_in}, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // table-driven single transactions (scenarios 1 and 2 lead the table)
        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i].m, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
            if (!tbl[i].we) last_rd[tbl[i].m] = tbl[i].exp_rd;
            if (i == 0) chk("mem_word16", 64'(mem1[16]), 64'h0000_0000_DEAD_BEEF);
        end
        chk("m0_rdata_hold", 64'(m0_rdata), 64'(last_rd[0]));
        chk("m1_rdata_hold", 64'(m1_rdata), 64'(last_rd[1]));

        // both masters reading continuously: 8 grants, fresh pointer
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
`ifdef DM_ARB_FIXED_PRI_EN
            em = 1'b0;
`else
            em = i[0];
`endif
            gnt_q.push_back(em);
            rd_q.push_back({em, em ? 32'hA5A5A5A5 : 32'h12345678});
        end
        m0_req = 1; m0_we = 0; m0_addr = 12'h010;
        m1_req = 1; m1_we = 0; m1_addr = 12'h000;
        ng = 0; cyc = 0; last = 0;
        while (ng < 8 && cyc < 100) begin
            tick();
            cyc++;
            if (m0_gnt || m1_gnt) begin
                if (ng > 0) chk("rr_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                ng++;
                if (ng == 8) begin
                    m0_req = 0;
                    m1_req = 0;
                end
            end
        end
        m0_req = 0;
        m1_req = 0;
        chk("rr_grants", 64'(ng), 64'd8);
        repeat (4) tick();

        // master 1 pulses req while master 0's read is in flight
        gnt_q.push_back(1'b0);
        rd_q.push_back({1'b0, 32'h12345678});
        e0 = en_cnt;
        m0_req = 1; m0_we = 0; m0_addr = 12'h010;
        tick();
        chk("wd_m0_gnt", {63'd0, m0_gnt}, 64'd1);
        m0_req = 0;
        m1_req = 1; m1_we = 1; m1_addr = 12'h030; m1_wdata = 32'hBAD0BAD0;
        tick();
        m1_req = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("wd_no_m1_gnt", {63'd0, m1_gnt}, 64'd0);
        end
        chk("wd_enable_pulses", 64'(en_cnt - e0), 64'd1);

        // MEM_LAT=3 read on u_dut3
        d3_m0_req = 1; d3_m0_we = 0; d3_m0_addr = 12'h0AB;
        tick();
        chk("l3_gnt", {61'd0, d3_m0_gnt, d3_en, d3_rd}, 64'd7);
        d3_m0_req = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("l3_wait", {62'd0, d3_en, d3_m0_rvalid}, 64'd0);
        end
        tick();
        chk("l3_rvalid", {63'd0, d3_m0_rvalid}, 64'd1);
        chk("l3_rdata", 64'(d3_m0_rdata), 64'h0000_0000_C0DE_00AB);
        tick();
        chk("l3_pulse", {63'd0, d3_m0_rvalid}, 64'd0);
        chk("l3_hold", 64'(d3_m0_rdata), 64'h0000_0000_C0DE_00AB);

        // reset during WAIT of a master 1 read on u_dut3
        d3_m1_req = 1; d3_m1_we = 0; d3_m1_addr = 12'h055;
        tick();
        chk("rw_m1_gnt", {63'd0, d3_m1_gnt}, 64'd1);
        d3_m1_req = 0;
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_async_ctl", {57'd0, d3_m0_gnt, d3_m1_gnt, d3_m0_rvalid, d3_m1_rvalid,
                              d3_en, d3_rd, d3_wr}, 64'd0);
        chk("rst_async_rdata", {d3_m0_rdata, d3_m1_rdata}, 64'd0);
        chk("rst_async_bus", {20'd0, d3_addr, d3_in}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("no_rvalid_after_rst", {63'd0, d3_m1_rvalid}, 64'd0);
        end
        d3_m0_req = 1; d3_m0_we = 1; d3_m0_addr = 12'h001;
        d3_m1_req = 1; d3_m1_we = 1; d3_m1_addr = 12'h002;
        tick();
        chk("tie_after_rst", {62'd0, d3_m1_gnt, d3_m0_gnt}, 64'd1);
        d3_m0_req = 0;
        d3_m1_req = 0;
        repeat (3) tick();

        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
